// File: rtl/video_stream_pkg.sv
// Shared types and constants for the video test-pattern source.
package video_stream_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID   = 3'd0,
    PAT_BARS    = 3'd1,
    PAT_RAMP    = 3'd2,
    PAT_CHECK   = 3'd3,
    PAT_MOVRAMP = 3'd4
  } pat_e;

  localparam int CTL_EN      = 31;
  localparam int CTL_PAT_LSB = 28;
  localparam int CTL_COL_MSB = 23;

  localparam logic [23:0] BAR_TAB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: maps (pattern, position, bar, frame) to RGB.
module video_pattern_pixel
  import video_stream_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic [2:0]    sel_i,
  input  logic [23:0]   colour_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [2:0]    bar_i,
  input  logic [7:0]    frame_cnt_i,
  output logic [23:0]   pixel_o
);

  // Zero-extend so narrow test geometries can still address x[7:0] and y[4].
  logic [15:0] xe, ye;
  logic [7:0]  mov;
  logic        unused_bits;

  assign xe          = 16'(x_i);
  assign ye          = 16'(y_i);
  assign mov         = xe[7:0] + frame_cnt_i;
  assign unused_bits = ^{xe[15:8], ye[15:5], ye[3:0]};

  always_comb begin
    pixel_o = colour_i;
    case (sel_i)
      PAT_BARS:    pixel_o = BAR_TAB[bar_i];
      PAT_RAMP:    pixel_o = {3{xe[7:0]}};
      PAT_CHECK:   pixel_o = (xe[4] ^ ye[4]) ? 24'hFFFFFF : 24'h000000;
      PAT_MOVRAMP: pixel_o = {3{mov}};
      default:     pixel_o = colour_i;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern master: control sync, frame FSM, counters and
// registered output beat.
module video_pattern_gen
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] ctl_reg,
  input  logic        m_axis_video_TREADY,
  output logic        m_axis_video_TVALID,
  output logic [23:0] m_axis_video_TDATA,
  output logic [2:0]  m_axis_video_TKEEP,
  output logic [2:0]  m_axis_video_TSTRB,
  output logic        m_axis_video_TUSER,
  output logic        m_axis_video_TLAST,
  output logic        m_axis_video_TID,
  output logic        m_axis_video_TDEST,
  output logic        frame_done,
  output logic        busy
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  state_e        state_q;
  logic [31:0]   sync1_q, sync2_q;
  logic [XW-1:0] x_q, x_d, bc_q, bc_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    bar_q, bar_d, sel_q, sel_d;
  logic [23:0]   col_q, col_d, pix;
  logic [7:0]    fc_q, fc_d;
  logic          tvalid_q, tuser_q, tlast_q, frame_done_q;
  logic [23:0]   tdata_q;
  logic          accept, last, start, adv, fin;
  logic          unused_ctl;

  assign accept     = tvalid_q & m_axis_video_TREADY;
  assign last       = (x_q == XW'(H_ACTIVE-1)) && (y_q == YW'(V_ACTIVE-1));
  assign unused_ctl = ^sync2_q[27:24];

  // Next-beat position and per-frame settings; the pixel is computed for the
  // beat about to be registered, so the output register is always in step.
  always_comb begin
    x_d = x_q; y_d = y_q; bar_d = bar_q; bc_d = bc_q;
    fc_d = fc_q; sel_d = sel_q; col_d = col_q;
    start = 1'b0; adv = 1'b0; fin = 1'b0;
    if (state_q == S_IDLE) begin
      start = sync2_q[CTL_EN];
    end else if (accept) begin
      if (last) begin
        fin   = 1'b1;
        fc_d  = fc_q + 8'd1;
        start = sync2_q[CTL_EN];
      end else begin
        adv = 1'b1;
      end
    end
    if (start || fin) begin
      x_d = '0; y_d = '0; bar_d = '0; bc_d = '0;
    end
    if (start) begin
      sel_d = sync2_q[CTL_PAT_LSB +: 3];
      col_d = sync2_q[CTL_COL_MSB:0];
    end
    if (adv) begin
      if (x_q == XW'(H_ACTIVE-1)) begin
        x_d = '0; y_d = y_q + 1'b1; bar_d = '0; bc_d = '0;
      end else begin
        x_d = x_q + 1'b1;
        if (bc_q == XW'(H_ACTIVE/8-1)) begin
          bc_d = '0; bar_d = bar_q + 3'd1;
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end
    end
  end

  video_pattern_pixel #(.XW(XW), .YW(YW)) u_pix (
    .sel_i       (sel_d),
    .colour_i    (col_d),
    .x_i         (x_d),
    .y_i         (y_d),
    .bar_i       (bar_d),
    .frame_cnt_i (fc_d),
    .pixel_o     (pix)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      sync1_q <= '0; sync2_q <= '0;
      x_q <= '0; y_q <= '0; bar_q <= '0; bc_q <= '0;
      fc_q <= '0; sel_q <= '0; col_q <= '0;
      tvalid_q <= 1'b0; tdata_q <= '0; tuser_q <= 1'b0; tlast_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q <= ctl_reg;
      sync2_q <= sync1_q;
      x_q <= x_d; y_q <= y_d; bar_q <= bar_d; bc_q <= bc_d;
      fc_q <= fc_d; sel_q <= sel_d; col_q <= col_d;
      frame_done_q <= fin;
      if (start || adv) begin
        state_q  <= S_ACTIVE;
        tvalid_q <= 1'b1;
        tdata_q  <= pix;
        tuser_q  <= start;
        tlast_q  <= (x_d == XW'(H_ACTIVE-1));
      end else if (fin) begin
        state_q  <= S_IDLE;
        tvalid_q <= 1'b0;
        tuser_q  <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign m_axis_video_TVALID = tvalid_q;
  assign m_axis_video_TDATA  = tdata_q;
  assign m_axis_video_TKEEP  = 3'b111;
  assign m_axis_video_TSTRB  = 3'b111;
  assign m_axis_video_TUSER  = tuser_q;
  assign m_axis_video_TLAST  = tlast_q;
  assign m_axis_video_TID    = 1'b0;
  assign m_axis_video_TDEST  = 1'b0;
  assign frame_done          = frame_done_q;
  assign busy                = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen at 16x4: expected beats are queued
// by the stimulus, a negedge monitor pops and compares accepted beats.
module tb_video_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        aclk, aresetn, tready;
  logic [31:0] ctl;
  logic        tvalid, tuser, tlast, tid, tdest, frame_done, busy;
  logic [23:0] tdata;
  logic [2:0]  tkeep, tstrb;

  video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .ctl_reg             (ctl),
    .m_axis_video_TREADY (tready),
    .m_axis_video_TVALID (tvalid),
    .m_axis_video_TDATA  (tdata),
    .m_axis_video_TKEEP  (tkeep),
    .m_axis_video_TSTRB  (tstrb),
    .m_axis_video_TUSER  (tuser),
    .m_axis_video_TLAST  (tlast),
    .m_axis_video_TID    (tid),
    .m_axis_video_TDEST  (tdest),
    .frame_done          (frame_done),
    .busy                (busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  beat_t       sb[$];
  int          n_chk = 0, n_err = 0;
  int          acc_cnt = 0, done_cnt = 0;
  logic        done_tv = 1'b0;
  logic        rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [26:0] held;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int pat, input logic [23:0] col,
                                          input int x, input int y, input int fc);
    logic [7:0] v;
    case (pat)
      1: exp_pix = bars[x / (H/8)];
      2: begin v = 8'(x); exp_pix = {v, v, v}; end
      3: exp_pix = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      4: begin v = 8'(x + fc); exp_pix = {v, v, v}; end
      default: exp_pix = col;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] col, input int fc);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        sb.push_back('{d: exp_pix(pat, col, x, y, fc), u: (x == 0 && y == 0), l: (x == H-1)});
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 2000) begin @(posedge aclk); t++; end
    if (acc_cnt < n) chk("wait_accept_timeout", 64'(acc_cnt), 64'(n));
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 2000) begin @(posedge aclk); t++; end
    if (done_cnt < n) chk("wait_done_timeout", 64'(done_cnt), 64'(n));
  endtask

  task automatic set_ctl(input logic [31:0] v);
    ctl = v;
  endtask

  // Ready driver: random when enabled, otherwise always ready.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard compare on acceptance, stability check while stalled.
  always @(negedge aclk) begin
    beat_t e;
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", 64'({tvalid, tdata, tuser, tlast}), 64'(held));
      if (frame_done) begin done_cnt++; done_tv = tvalid; end
      if (tvalid && tready) begin
        if (sb.size() == 0) chk("unexpected_beat_data", 64'(tdata), 64'hx);
        else begin
          e = sb.pop_front();
          chk("beat", 64'({tdata, tuser, tlast}), 64'({e.d, e.u, e.l}));
        end
        acc_cnt++;
      end
      stall_prev = tvalid && !tready;
      held = {tvalid, tdata, tuser, tlast};
    end
  end

  initial begin
    int a0;
    aresetn = 1'b0;
    ctl = 32'h0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tuser_tlast", 64'({tuser, tlast}), 64'd0);
    chk("rst_busy_done", 64'({busy, frame_done}), 64'd0);
    chk("const_keep_strb_id_dest", 64'({tkeep, tstrb, tid, tdest}), 64'b11111100);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Solid 0x001234; latency of three clocks from enable.
    push_frame(0, 24'h001234, 0);
    set_ctl(32'h8000_1234);
    @(posedge aclk); #1; chk("lat_edge1", 64'(tvalid), 64'd0);
    @(posedge aclk); #1; chk("lat_edge2", 64'(tvalid), 64'd0);
    @(posedge aclk); #1; chk("lat_edge3", 64'(tvalid), 64'd1);
    chk("busy_active", 64'(busy), 64'd1);
    wait_acc(1);
    set_ctl(32'h0000_1234);
    wait_done(1);
    #1;
    chk("f1_beats", 64'(acc_cnt), 64'd64);
    chk("f1_idle", 64'({tvalid, busy}), 64'd0);

    // Colour bars; enable dropped at beat 10, frame still completes.
    push_frame(1, 24'h0, 1);
    set_ctl(32'h9000_0000);
    wait_acc(64 + 10);
    set_ctl(32'h1000_0000);
    wait_done(2);
    #1;
    chk("f2_beats", 64'(acc_cnt), 64'd128);
    chk("f2_tvalid_at_done", 64'(done_tv), 64'd0);
    chk("f2_idle", 64'({tvalid, busy}), 64'd0);

    // Moving ramp under random backpressure.
    rand_rdy = 1'b1;
    push_frame(4, 24'h0, 2);
    set_ctl(32'hC000_0000);
    wait_acc(128 + 5);
    set_ctl(32'h0);
    wait_done(3);
    rand_rdy = 1'b0;
    #1;
    chk("f3_beats", 64'(acc_cnt), 64'd192);

    // Mid-frame pattern change takes effect only on the next, back-to-back frame.
    push_frame(0, 24'h0000AB, 3);
    push_frame(2, 24'h0000AB, 4);
    set_ctl(32'h8000_00AB);
    wait_acc(192 + 20);
    set_ctl(32'hA000_00AB);
    wait_done(4);
    chk("b2b_tvalid_at_done", 64'(done_tv), 64'd1);
    wait_acc(256 + 2);
    set_ctl(32'h2000_00AB);
    wait_done(5);
    #1;
    chk("f5_beats", 64'(acc_cnt), 64'd320);
    chk("f5_idle", 64'({tvalid, busy}), 64'd0);

    // Reset mid-frame, then restart from (0,0) with frame counter cleared.
    push_frame(4, 24'h0, 5);
    set_ctl(32'hC000_0000);
    wait_acc(320 + 30);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_rst_out", 64'({tvalid, tuser, tlast, busy}), 64'd0);
    sb.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    push_frame(4, 24'h0, 0);
    a0 = acc_cnt;
    wait_acc(a0 + 1);
    set_ctl(32'h0);
    wait_done(6);
    #1;
    chk("post_rst_beats", 64'(acc_cnt - a0), 64'd64);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
